// File: rtl/apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// apb_fsm_controller
//
// APB-side sequencer of the AHB2APB bridge. It takes a qualified, registered
// AHB request from the slave interface and runs the APB SETUP/ENABLE handshake
// to one of NSEL peripherals. While an APB transfer is in flight it holds
// hreadyout low to stall the AHB master. Read data does not pass through this
// block.
//
// Optional feature macro: APB_WAIT_EN
//   defined   : ENABLE is extended while pready=0 (peripheral wait states).
//   undefined : pready is ignored and ENABLE always lasts exactly one cycle.
//
// Ports
//   hclk        in   bridge clock, rising edge
//   hreset      in   asynchronous active-high reset
//   valid       in   qualified AHB transfer to bridge space (address phase)
//   hwrite_reg  in   registered hwrite, 1 = write
//   haddr_1     in   registered haddr           [ADDR_W]
//   hwdata_1    in   registered hwdata          [DATA_W]
//   temp_sel    in   one-hot peripheral select  [NSEL]
//   pready      in   APB ready (used only with APB_WAIT_EN)
//   psel        out  APB select, one-hot or 0   [NSEL]
//   penable     out  APB enable
//   pwrite      out  APB direction
//   paddr       out  APB address                [ADDR_W]
//   pwdata      out  APB write data             [DATA_W]
//   hreadyout   out  to AHB, 0 stalls the master
// -----------------------------------------------------------------------------
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr_1,
  input  logic [DATA_W-1:0] hwdata_1,
  input  logic [NSEL-1:0]   temp_sel,
  input  logic              pready,
  output logic [NSEL-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] paddr_q;   // captured request address (write path)
  logic [NSEL-1:0]   sel_q;     // captured peripheral select
  logic [ADDR_W-1:0] paddr_r;   // address presented on the APB bus
  logic              pwrite_r;  // direction presented on the APB bus
  logic [DATA_W-1:0] pwdata_r;  // write data presented on the APB bus

  logic enable_st;  // in an ENABLE phase
  logic stall;      // ENABLE phase extended by the peripheral
  logic capture;    // a new request is accepted this cycle

  assign enable_st = (state == ST_RENABLE) || (state == ST_WENABLE);

`ifdef APB_WAIT_EN
  assign stall = enable_st && !pready;
`else
  logic unused_pready;
  assign unused_pready = pready;
  assign stall = 1'b0;
`endif

  // Requests are only accepted in the states where hreadyout is high, and
  // never while the peripheral is holding off the ENABLE phase.
  assign capture = valid && ((state == ST_IDLE) || (enable_st && !stall));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of the order of statements.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    psel       = '0;
    penable    = 1'b0;
    hreadyout  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (valid) state_next = hwrite_reg ? ST_WWAIT : ST_READ;
      end
      ST_READ: begin
        psel       = sel_q;
        hreadyout  = 1'b0;
        state_next = ST_RENABLE;
      end
      ST_WWAIT: begin
        hreadyout  = 1'b0;
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        psel       = sel_q;
        hreadyout  = 1'b0;
        state_next = ST_WENABLE;
      end
      ST_RENABLE, ST_WENABLE: begin
        psel    = sel_q;
        penable = 1'b1;
        // With wait states enabled this is the only path from an input
        // (pready) to an output; it is inherent to extending ENABLE.
        hreadyout = !stall;
        if (!stall) begin
          if (valid) state_next = hwrite_reg ? ST_WWAIT : ST_READ;
          else       state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;  // unused encodings, outputs idle
    endcase
  end

  // Request and bus-side registers. Reads go straight to SETUP, so the bus
  // address/direction are loaded at capture; writes load them when leaving
  // WWAIT so the bus keeps its previous values during WWAIT.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      paddr_q  <= '0;
      sel_q    <= '0;
      paddr_r  <= '0;
      pwrite_r <= 1'b0;
      pwdata_r <= '0;
    end else begin
      if (capture) begin
        paddr_q <= haddr_1;
        sel_q   <= temp_sel;
        if (!hwrite_reg) begin
          paddr_r  <= haddr_1;
          pwrite_r <= 1'b0;
        end
      end
      if (state == ST_WWAIT) begin
        paddr_r  <= paddr_q;
        pwrite_r <= 1'b1;
        pwdata_r <= hwdata_1;
      end
    end
  end

  assign paddr  = paddr_r;
  assign pwrite = pwrite_r;
  assign pwdata = pwdata_r;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_fsm_controller
//
// Directed self-checking bench for apb_fsm_controller. Inputs change just
// after a rising edge; outputs are compared 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_fsm_controller;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NSEL   = 3;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              valid;
  logic              hwrite_reg;
  logic [ADDR_W-1:0] haddr_1;
  logic [DATA_W-1:0] hwdata_1;
  logic [NSEL-1:0]   temp_sel;
  logic              pready;
  logic [NSEL-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              hreadyout;

  int n_tests = 0;
  int n_fail  = 0;

  apb_fsm_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .valid      (valid),
    .hwrite_reg (hwrite_reg),
    .haddr_1    (haddr_1),
    .hwdata_1   (hwdata_1),
    .temp_sel   (temp_sel),
    .pready     (pready),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hreadyout  (hreadyout)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the handshake outputs in one call.
  task automatic check_bus(input string tag, input logic [2:0] e_psel,
                           input logic e_pen, input logic e_rdy);
    check({tag, ".psel"}, 32'(psel), 32'(e_psel));
    check({tag, ".penable"}, 32'(penable), 32'(e_pen));
    check({tag, ".hreadyout"}, 32'(hreadyout), 32'(e_rdy));
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [31:0] addr, input logic [2:0] sel);
    valid      = 1'b1;
    hwrite_reg = wr;
    haddr_1    = addr;
    temp_sel   = sel;
  endtask

  initial begin
    hreset     = 1'b1;
    valid      = 1'b0;
    hwrite_reg = 1'b0;
    haddr_1    = '0;
    hwdata_1   = '0;
    temp_sel   = '0;
    pready     = 1'b1;

    // Reset state
    #3;
    check_bus("rst", 3'b000, 1'b0, 1'b1);
    check("rst.paddr", paddr, 32'h0);
    check("rst.pwdata", pwdata, 32'h0);
    check("rst.pwrite", 32'(pwrite), 32'h0);
    tick();
    tick();
    #2 hreset = 1'b0;
    tick();
    check_bus("idle", 3'b000, 1'b0, 1'b1);

    // 1. Single read
    req(1'b0, 32'h8000_0010, 3'b001);
    tick();
    valid = 1'b0;
    check_bus("t1.read", 3'b001, 1'b0, 1'b0);
    check("t1.read.paddr", paddr, 32'h8000_0010);
    check("t1.read.pwrite", 32'(pwrite), 32'h0);
    tick();
    check_bus("t1.renable", 3'b001, 1'b1, 1'b1);
    tick();
    check_bus("t1.idle", 3'b000, 1'b0, 1'b1);
    check("t1.idle.paddr_hold", paddr, 32'h8000_0010);

    // 2. Single write, data one cycle after the address phase
    req(1'b1, 32'h8400_0004, 3'b010);
    tick();
    valid    = 1'b0;
    hwdata_1 = 32'hDEAD_BEEF;
    check_bus("t2.wwait", 3'b000, 1'b0, 1'b0);
    check("t2.wwait.paddr_hold", paddr, 32'h8000_0010);
    check("t2.wwait.pwrite_hold", 32'(pwrite), 32'h0);
    tick();
    hwdata_1 = 32'h0;
    check_bus("t2.write", 3'b010, 1'b0, 1'b0);
    check("t2.write.pwrite", 32'(pwrite), 32'h1);
    check("t2.write.paddr", paddr, 32'h8400_0004);
    check("t2.write.pwdata", pwdata, 32'hDEAD_BEEF);
    tick();
    check_bus("t2.wenable", 3'b010, 1'b1, 1'b1);
    check("t2.wenable.pwdata", pwdata, 32'hDEAD_BEEF);
    tick();
    check_bus("t2.idle", 3'b000, 1'b0, 1'b1);
    check("t2.idle.pwrite_hold", 32'(pwrite), 32'h1);

    // 3. Back-to-back read -> write -> read
    req(1'b0, 32'h8800_0000, 3'b100);
    tick();
    valid = 1'b0;
    check_bus("t3.read", 3'b100, 1'b0, 1'b0);
    check("t3.read.pwrite", 32'(pwrite), 32'h0);
    tick();
    check_bus("t3.renable", 3'b100, 1'b1, 1'b1);
    req(1'b1, 32'h8000_0008, 3'b001);
    tick();
    valid    = 1'b0;
    hwdata_1 = 32'h1234_5678;
    check_bus("t3.wwait", 3'b000, 1'b0, 1'b0);
    check("t3.wwait.paddr_hold", paddr, 32'h8800_0000);
    tick();
    check_bus("t3.write", 3'b001, 1'b0, 1'b0);
    check("t3.write.paddr", paddr, 32'h8000_0008);
    check("t3.write.pwdata", pwdata, 32'h1234_5678);
    tick();
    check_bus("t3.wenable", 3'b001, 1'b1, 1'b1);
    req(1'b0, 32'h8000_0020, 3'b010);
    tick();
    valid = 1'b0;
    check_bus("t3.read2", 3'b010, 1'b0, 1'b0);
    check("t3.read2.paddr", paddr, 32'h8000_0020);
    check("t3.read2.pwrite", 32'(pwrite), 32'h0);
    tick();
    check_bus("t3.renable2", 3'b010, 1'b1, 1'b1);
    tick();
    check_bus("t3.idle", 3'b000, 1'b0, 1'b1);

    // 4. Asynchronous reset in WRITE, then a normal read
    req(1'b1, 32'h8400_0040, 3'b010);
    tick();
    valid    = 1'b0;
    hwdata_1 = 32'hCAFE_0001;
    tick();
    check_bus("t4.write", 3'b010, 1'b0, 1'b0);
    #2 hreset = 1'b1;
    #1;
    check_bus("t4.rst", 3'b000, 1'b0, 1'b1);
    check("t4.rst.paddr", paddr, 32'h0);
    check("t4.rst.pwdata", pwdata, 32'h0);
    check("t4.rst.pwrite", 32'(pwrite), 32'h0);
    tick();
    #2 hreset = 1'b0;
    tick();
    check_bus("t4.after", 3'b000, 1'b0, 1'b1);
    req(1'b0, 32'h8000_0010, 3'b001);
    tick();
    valid = 1'b0;
    check_bus("t4.read", 3'b001, 1'b0, 1'b0);
    check("t4.read.paddr", paddr, 32'h8000_0010);
    tick();
    check_bus("t4.renable", 3'b001, 1'b1, 1'b1);
    tick();
    check_bus("t4.idle", 3'b000, 1'b0, 1'b1);

`ifdef APB_WAIT_EN
    // 5. ENABLE extended by pready=0 for three cycles
    req(1'b0, 32'h8800_0100, 3'b100);
    tick();
    valid  = 1'b0;
    pready = 1'b0;
    check_bus("t5.read", 3'b100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus($sformatf("t5.wait%0d", i), 3'b100, 1'b1, 1'b0);
      check($sformatf("t5.wait%0d.paddr", i), paddr, 32'h8800_0100);
    end
    pready = 1'b1;
    #1;
    check_bus("t5.ready", 3'b100, 1'b1, 1'b1);
    tick();
    check_bus("t5.idle", 3'b000, 1'b0, 1'b1);
`else
    // 5. pready ignored: ENABLE lasts exactly one cycle
    req(1'b0, 32'h8800_0100, 3'b100);
    tick();
    valid  = 1'b0;
    pready = 1'b0;
    check_bus("t5.read", 3'b100, 1'b0, 1'b0);
    tick();
    check_bus("t5.renable", 3'b100, 1'b1, 1'b1);
    tick();
    check_bus("t5.idle", 3'b000, 1'b0, 1'b1);
    pready = 1'b1;
`endif

    // 6. valid toggled while the master is stalled has no effect
    req(1'b1, 32'h8400_0200, 3'b010);
    tick();
    hwdata_1 = 32'hA5A5_5A5A;
    valid    = 1'b1;            // in WWAIT
    check_bus("t6.wwait", 3'b000, 1'b0, 1'b0);
    tick();
    valid = 1'b0;               // in WRITE
    check_bus("t6.write", 3'b010, 1'b0, 1'b0);
    check("t6.write.paddr", paddr, 32'h8400_0200);
    check("t6.write.pwdata", pwdata, 32'hA5A5_5A5A);
    tick();
    check_bus("t6.wenable", 3'b010, 1'b1, 1'b1);
    tick();
    check_bus("t6.idle", 3'b000, 1'b0, 1'b1);
    req(1'b0, 32'h8000_0300, 3'b001);
    tick();
    hwrite_reg = 1'b1;          // in READ, valid still high
    tick();
    valid = 1'b0;               // in RENABLE
    check_bus("t6.renable", 3'b001, 1'b1, 1'b1);
    check("t6.renable.paddr", paddr, 32'h8000_0300);
    check("t6.renable.pwrite", 32'(pwrite), 32'h0);
    tick();
    check_bus("t6.idle2", 3'b000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
